// File: rtl/jtdd2_pkg.sv
// jtdd2_pkg: shared state encoding and default timing for the shared-RAM arbiter
package jtdd2_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GRANT, S_REL, S_ABORT} state_t;
  localparam int HOLD_DEF = 8;
  localparam int TOUT_DEF = 1024;
endpackage

// File: rtl/jtdd2_share_arb_if.sv
// jtdd2_share_arb_if: main/sub shared-RAM handshake bundle
interface jtdd2_share_arb_if;
  logic main_cs, main_wrn, sw_halt, mcu_ban;
  logic mcu_halt, main_wait, ram_we, rd_ff, granted, tout_err;
  modport master (
    output main_cs, main_wrn, sw_halt, mcu_ban,
    input  mcu_halt, main_wait, ram_we, rd_ff, granted, tout_err
  );
  modport slave (
    input  main_cs, main_wrn, sw_halt, mcu_ban,
    output mcu_halt, main_wait, ram_we, rd_ff, granted, tout_err
  );
endinterface

// File: rtl/jtdd2_share_tmr.sv
// jtdd2_share_tmr: loadable saturating up/down counter with terminal-count flag
module jtdd2_share_tmr #(
  parameter int         W    = 8,
  parameter bit         UP   = 1'b0,
  parameter logic [W-1:0] TERM = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen_i,
  input  logic         load_i,
  input  logic [W-1:0] ld_val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         sat;
  always_comb begin
    sat   = UP ? cnt_q == TERM : cnt_q == '0;
    cnt_d = load_i ? ld_val_i : (cen_i && !sat) ? (UP ? cnt_q + 1'b1 : cnt_q - 1'b1) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc_o = cnt_q == TERM;
endmodule

// File: rtl/jtdd2_share_arb.sv
// jtdd2_share_arb: sequences main-CPU access to the sub-CPU shared RAM via bus halt
module jtdd2_share_arb
  import jtdd2_pkg::*;
#(
  parameter int HOLD = HOLD_DEF,
  parameter int TOUT = TOUT_DEF
) (
  input logic clk,
  input logic rst,
  input logic cen4,
  jtdd2_share_arb_if.slave bus
);
  localparam int TW = $clog2(TOUT);
  state_t st_q, st_d;
  logic   err_q, err_d, acc, hold_tc, tout_tc;
  assign acc = bus.main_cs | bus.sw_halt;
  // hold sits preloaded outside GRANT, so entering GRANT always starts a full linger
  jtdd2_share_tmr #(.W(8), .UP(1'b0), .TERM(8'd1)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .cen_i    (cen4 && st_q == S_GRANT),
    .load_i   (st_q != S_GRANT || acc),
    .ld_val_i (8'(HOLD)),
    .tc_o     (hold_tc)
  );
  jtdd2_share_tmr #(.W(TW), .UP(1'b1), .TERM(TW'(TOUT - 1))) u_tout (
    .clk      (clk),
    .rst      (rst),
    .cen_i    (cen4 && st_q == S_REQ && bus.mcu_ban),
    .load_i   (st_q != S_REQ),
    .ld_val_i ('0),
    .tc_o     (tout_tc)
  );
  always_comb begin
    st_d = st_q;
    if (cen4)
      case (st_q)
        S_IDLE:  st_d = acc ? S_REQ : S_IDLE;
        S_REQ:   st_d = !bus.mcu_ban ? S_GRANT : tout_tc ? S_ABORT : S_REQ;
        S_GRANT: st_d = bus.mcu_ban ? S_REQ : (!acc && hold_tc) ? S_REL : S_GRANT;
        S_REL:   st_d = acc ? S_REQ : bus.mcu_ban ? S_IDLE : S_REL;
        S_ABORT: st_d = acc ? S_ABORT : S_IDLE;
        default: st_d = S_IDLE;
      endcase
    err_d = err_q | (st_q == S_REQ && st_d == S_ABORT);
  end
  always_ff @(posedge clk) begin
    st_q  <= rst ? S_IDLE : st_d;
    err_q <= rst ? 1'b0 : err_d;
  end
  assign bus.mcu_halt  = st_q == S_REQ || st_q == S_GRANT;
  assign bus.granted   = st_q == S_GRANT;
  assign bus.main_wait = !rst && bus.main_cs && st_q != S_GRANT && st_q != S_ABORT;
  assign bus.ram_we    = st_q == S_GRANT && bus.main_cs && !bus.main_wrn && !bus.mcu_ban;
  assign bus.rd_ff     = st_q == S_ABORT && bus.main_cs;
  assign bus.tout_err  = err_q;
endmodule

// File: tb/tb_jtdd2_share_arb.sv
// tb_jtdd2_share_arb: directed stimulus checked against a flag-based behavioural model
module tb_jtdd2_share_arb;
  localparam int HOLD = 8;
  localparam int TOUT = 1024;
  logic clk = 1'b0, rst, cen4;
  jtdd2_share_arb_if bus ();
  jtdd2_share_arb #(.HOLD(HOLD), .TOUT(TOUT)) dut (.clk(clk), .rst(rst), .cen4(cen4), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // model: sub requested, sub owned, halt dropped awaiting ack, aborted, sticky error
  bit m_req, m_own, m_drop, m_abort, m_err;
  int m_waited, m_left;
  logic m_acc;
  always @(posedge clk) begin
    m_acc = bus.main_cs | bus.sw_halt;
    if (rst) begin
      {m_req, m_own, m_drop, m_abort, m_err} = '0;
      m_waited = 0;
      m_left = 0;
    end else begin
      if (m_own && m_acc) m_left = HOLD;
      if (cen4) begin
        if (m_abort) m_abort = m_acc;
        else if (m_own) begin
          if (bus.mcu_ban) begin m_own = 0; m_req = 1; m_waited = 0; end
          else if (!m_acc) begin
            m_left--;
            if (m_left == 0) begin m_own = 0; m_drop = 1; end
          end
        end else if (m_req) begin
          if (!bus.mcu_ban) begin m_req = 0; m_own = 1; m_left = HOLD; end
          else begin
            m_waited++;
            if (m_waited == TOUT) begin m_req = 0; m_abort = 1; m_err = 1; end
          end
        end else if (m_drop) begin
          if (m_acc) begin m_drop = 0; m_req = 1; m_waited = 0; end
          else if (bus.mcu_ban) m_drop = 0;
        end else if (m_acc) begin m_req = 1; m_waited = 0; end
      end
    end
  end

  int rises = 0, falls = 0, we_cnt = 0;
  logic prev_halt = 1'b0;
  always @(negedge clk) begin
    chk("mcu_halt", bus.mcu_halt, m_req || m_own);
    chk("granted", bus.granted, m_own);
    chk("main_wait", bus.main_wait, !rst && bus.main_cs && !m_own && !m_abort);
    chk("ram_we", bus.ram_we, m_own && bus.main_cs && !bus.main_wrn && !bus.mcu_ban);
    chk("rd_ff", bus.rd_ff, m_abort && bus.main_cs);
    chk("tout_err", bus.tout_err, m_err);
    if (bus.ram_we) chk("we_invariant", bus.granted && !bus.mcu_ban, 1);
    if (bus.mcu_halt && !prev_halt) rises++;
    if (!bus.mcu_halt && prev_halt) falls++;
    if (bus.ram_we) we_cnt++;
    prev_halt = bus.mcu_halt;
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_access(input logic wr, output int waits, output logic rdff);
    bit ok = 0;
    waits = 0;
    rdff = 0;
    bus.main_cs = 1;
    bus.main_wrn = ~wr;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.main_wait) begin ok = 1; rdff = bus.rd_ff; break; end
      waits++;
      tick(1);
    end
    chk("access_bound", ok, 1);
    tick(1);
    bus.main_cs = 0;
    bus.main_wrn = 1;
  endtask

  task automatic linger(output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.mcu_halt) begin ok = 1; break; end
      n++;
      tick(1);
    end
    chk("linger_bound", ok, 1);
    tick(1);
  endtask

  task automatic settle();
    bus.mcu_ban = 1;
    tick(2);
  endtask

  task automatic all_zero(string nm);
    @(negedge clk);
    chk({nm, "_halt"}, bus.mcu_halt, 0);
    chk({nm, "_wait"}, bus.main_wait, 0);
    chk({nm, "_granted"}, bus.granted, 0);
    chk({nm, "_err"}, bus.tout_err, 0);
    chk({nm, "_we"}, bus.ram_we, 0);
    chk({nm, "_rdff"}, bus.rd_ff, 0);
  endtask

  int w, tw, nw, nwe, nh, r0, f0, we0;
  logic r;
  logic [8:0] ew, ewe, egr;
  initial begin
    rst = 1; cen4 = 1;
    bus.main_cs = 0; bus.main_wrn = 1; bus.sw_halt = 0; bus.mcu_ban = 1;
    tick(3);
    all_zero("reset");
    tick(1);
    rst = 0;
    tick(1);
    // single write, sub acknowledges after 3 ticks of halt
    bus.main_cs = 1; bus.main_wrn = 0; nw = 0; nwe = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nw += int'(bus.main_wait);
      nwe += int'(bus.ram_we);
      if (i == 4) chk("t1_granted", bus.granted, 1);
      tick(1);
      if (i == 2) bus.mcu_ban = 0;
      if (i == 4) begin bus.main_cs = 0; bus.main_wrn = 1; end
    end
    chk("t1_wait_cycles", nw, 4);
    chk("t1_we_pulses", nwe, 1);
    linger(nh);
    chk("t1_linger", nh, HOLD);
    settle();
    // burst of 5 writes two ticks apart, then one access on the last hold tick
    bus.mcu_ban = 0;
    tick(1);
    r0 = rises; f0 = falls; tw = 0;
    for (int k = 0; k < 5; k++) begin
      do_access(1, w, r);
      tw += w;
      if (k < 4) tick(2);
    end
    tick(7);
    do_access(0, w, r);
    tw += w;
    chk("t2_waits", tw, 2);
    chk("t2_rises", rises - r0, 1);
    chk("t2_falls", falls - f0, 0);
    linger(nh);
    chk("t2_linger", nh, HOLD);
    settle();
    // sub never acknowledges
    we0 = we_cnt;
    do_access(0, w, r);
    chk("t3_waits", w, TOUT + 1);
    chk("t3_rdff", r, 1);
    @(negedge clk);
    chk("t3_err", bus.tout_err, 1);
    chk("t3_halt", bus.mcu_halt, 0);
    tick(1);
    @(negedge clk);
    chk("t3_err_sticky", bus.tout_err, 1);
    chk("t3_no_we", we_cnt - we0, 0);
    tick(1);
    // software halt for 100 ticks
    bus.sw_halt = 1; nh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      nh += int'(bus.mcu_halt);
      tick(1);
      if (i == 1) bus.mcu_ban = 0;
    end
    chk("t4_halt_cycles", nh, 99);
    bus.sw_halt = 0;
    linger(nh);
    chk("t4_linger", nh, HOLD);
    settle();
    // sub loses halt in the middle of a grant
    bus.mcu_ban = 0;
    tick(1);
    ew = 9'b011110011; ewe = 9'b100000100; egr = 9'b100001100;
    bus.main_cs = 1; bus.main_wrn = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t5_wait", bus.main_wait, ew[i]);
      chk("t5_we", bus.ram_we, ewe[i]);
      chk("t5_granted", bus.granted, egr[i]);
      tick(1);
      if (i == 2) bus.mcu_ban = 1;
      if (i == 6) bus.mcu_ban = 0;
    end
    bus.main_cs = 0; bus.main_wrn = 1;
    linger(nh);
    chk("t5_linger", nh, HOLD);
    settle();
    // reset while requesting, then while granted
    bus.main_cs = 1;
    tick(3);
    rst = 1;
    tick(1);
    all_zero("t6_req_rst");
    tick(1);
    rst = 0; bus.main_cs = 0; bus.mcu_ban = 0;
    tick(1);
    do_access(1, w, r);
    chk("t6_after_req_waits", w, 2);
    linger(nh);
    settle();
    bus.mcu_ban = 0;
    tick(1);
    bus.main_cs = 1; bus.main_wrn = 0;
    tick(2);
    @(negedge clk);
    chk("t6_in_grant", bus.granted, 1);
    tick(1);
    rst = 1;
    tick(1);
    all_zero("t6_grant_rst");
    tick(1);
    rst = 0; bus.main_cs = 0; bus.main_wrn = 1;
    tick(1);
    do_access(1, w, r);
    chk("t6_after_grant_waits", w, 2);
    linger(nh);
    settle();
    // abort held by sw_halt must not retry until it drops
    bus.sw_halt = 1;
    tick(TOUT + 6);
    nh = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nh += int'(bus.mcu_halt);
      tick(1);
    end
    chk("t7_no_retry", nh, 0);
    chk("t7_err", bus.tout_err, 1);
    bus.sw_halt = 0;
    tick(2);
    // sparse clock enable, checked by the model only
    bus.mcu_ban = 0;
    fork
      do_access(1, w, r);
      begin
        for (int i = 0; i < 12; i++) begin cen4 = ~cen4; tick(1); end
        cen4 = 1;
      end
    join
    linger(nh);
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached limit %0d", $time, 1000000);
    $fatal(1);
  end
endmodule
